// File: rtl/strength_pkg.sv
// Shared encodings for the strength resolver: drive strengths, 4-state
// result codes, resolution modes, and the per-bit resolution function.
package strength_pkg;

  typedef enum logic [2:0] {
    STR_HIGHZ  = 3'd0,
    STR_SMALL  = 3'd1,
    STR_MEDIUM = 3'd2,
    STR_WEAK   = 3'd3,
    STR_LARGE  = 3'd4,
    STR_PULL   = 3'd5,
    STR_STRONG = 3'd6,
    STR_SUPPLY = 3'd7
  } strength_e;

  typedef enum logic [1:0] {
    V4_ZERO = 2'b00,
    V4_ONE  = 2'b01,
    V4_Z    = 2'b10,
    V4_X    = 2'b11
  } val4_e;

  typedef enum logic [1:0] {
    MODE_WIRE = 2'd0,
    MODE_WAND = 2'd1,
    MODE_WOR  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef struct packed {
    logic [1:0] val;
    logic [2:0] str;
  } res_t;

  localparam int MAX_NDRV = 16;

  function automatic logic [2:0] max3(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

  // Equal nonzero strengths are the only contention case; the mode decides
  // whether that collapses to X, 0 or 1. The reserved mode behaves as wire.
  function automatic res_t resolve_bit(input logic [2:0] max0,
                                       input logic [2:0] max1,
                                       input logic [1:0] mode);
    res_t r;
    r.val = V4_Z;
    r.str = STR_HIGHZ;
    if (max0 == STR_HIGHZ && max1 == STR_HIGHZ) begin
      r.val = V4_Z;
      r.str = STR_HIGHZ;
    end else if (max0 > max1) begin
      r.val = V4_ZERO;
      r.str = max0;
    end else if (max1 > max0) begin
      r.val = V4_ONE;
      r.str = max1;
    end else begin
      r.str = max0;
      case (mode_e'(mode))
        MODE_WAND: r.val = V4_ZERO;
        MODE_WOR:  r.val = V4_ONE;
        default:   r.val = V4_X;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/strength_max_tree.sv
// Balanced maximum over NDRV 3-bit strengths; unused leaves read as highz
// so any driver count from 2 to 16 maps onto the same four-level tree.
module strength_max_tree
  import strength_pkg::*;
#(
  parameter int NDRV = 4
) (
  input  logic [NDRV*3-1:0] str_i,
  output logic [2:0]        max_o
);

  logic [2:0] lvl0 [MAX_NDRV];
  logic [2:0] lvl1 [MAX_NDRV/2];
  logic [2:0] lvl2 [MAX_NDRV/4];
  logic [2:0] lvl3 [MAX_NDRV/8];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_NDRV; gi++) begin : g_leaf
      if (gi < NDRV) begin : g_used
        assign lvl0[gi] = str_i[gi*3 +: 3];
      end else begin : g_pad
        assign lvl0[gi] = STR_HIGHZ;
      end
    end

    for (gi = 0; gi < MAX_NDRV/2; gi++) begin : g_l1
      assign lvl1[gi] = max3(lvl0[2*gi], lvl0[2*gi+1]);
    end

    for (gi = 0; gi < MAX_NDRV/4; gi++) begin : g_l2
      assign lvl2[gi] = max3(lvl1[2*gi], lvl1[2*gi+1]);
    end

    for (gi = 0; gi < MAX_NDRV/8; gi++) begin : g_l3
      assign lvl3[gi] = max3(lvl2[2*gi], lvl2[2*gi+1]);
    end
  endgenerate

  assign max_o = max3(lvl3[0], lvl3[1]);

endmodule

// File: rtl/strength_resolver.sv
// Two-stage multi-driver net resolver: stage 1 reduces per-bit 0/1 strength
// maxima, stage 2 resolves them to a 4-state value and tracks X results.
module strength_resolver
  import strength_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NDRV  = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [NDRV*WIDTH-1:0] drv_val,
  input  logic [NDRV*3-1:0]     drv_s0,
  input  logic [NDRV*3-1:0]     drv_s1,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  output logic [2*WIDTH-1:0]    out_val,
  output logic [3*WIDTH-1:0]    out_str,
  output logic                  x_sticky,
  output logic [CNT_W-1:0]      x_count,
  input  logic                  clr
);

  logic [3*WIDTH-1:0] max0_d, max1_d;
  logic [3*WIDTH-1:0] max0_q, max1_q;
  logic [1:0]         mode_q;
  logic               v1_q;

  logic [2*WIDTH-1:0] out_val_d, out_val_q;
  logic [3*WIDTH-1:0] out_str_d, out_str_q;
  logic               any_x_d;
  logic               out_valid_q;
  logic               x_sticky_q;
  logic [CNT_W-1:0]   x_count_q;

  genvar gi, gj;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [NDRV*3-1:0] cand0, cand1;

      // A driver only offers its strength to the polarity it is driving.
      for (gj = 0; gj < NDRV; gj++) begin : g_drv
        assign cand0[gj*3 +: 3] = drv_val[gj*WIDTH + gi] ? 3'd0 : drv_s0[gj*3 +: 3];
        assign cand1[gj*3 +: 3] = drv_val[gj*WIDTH + gi] ? drv_s1[gj*3 +: 3] : 3'd0;
      end

      strength_max_tree #(.NDRV(NDRV)) u_max0 (
        .str_i (cand0),
        .max_o (max0_d[gi*3 +: 3])
      );

      strength_max_tree #(.NDRV(NDRV)) u_max1 (
        .str_i (cand1),
        .max_o (max1_d[gi*3 +: 3])
      );
    end
  endgenerate

  always_comb begin
    res_t r;
    out_val_d = '0;
    out_str_d = '0;
    any_x_d   = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      r = resolve_bit(max0_q[b*3 +: 3], max1_q[b*3 +: 3], mode_q);
      out_val_d[b*2 +: 2] = r.val;
      out_str_d[b*3 +: 3] = r.str;
      if (r.val == V4_X) begin
        any_x_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      max0_q <= '0;
      max1_q <= '0;
      mode_q <= MODE_WIRE;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        max0_q <= max0_d;
        max1_q <= max1_d;
        mode_q <= mode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_val_q   <= {WIDTH{V4_Z}};
      out_str_q   <= '0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        out_val_q <= out_val_d;
        out_str_q <= out_str_d;
      end
    end
  end

  // X statistics are booked on the same edge the result is registered,
  // so a clear landing on that edge discards the event.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x_sticky_q <= 1'b0;
      x_count_q  <= '0;
    end else if (v1_q && any_x_d) begin
      x_sticky_q <= 1'b1;
      if (x_count_q != {CNT_W{1'b1}}) begin
        x_count_q <= x_count_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_val   = out_val_q;
  assign out_str   = out_str_q;
  assign x_sticky  = x_sticky_q;
  assign x_count   = x_count_q;

endmodule

// File: tb/tb_strength_resolver.sv
// Scoreboard bench for strength_resolver: directed vectors push expected
// results; a negedge monitor pops and compares whenever out_valid is seen.
module tb_strength_resolver;

  localparam int WIDTH = 8;
  localparam int NDRV  = 4;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic [NDRV*WIDTH-1:0] drv_val;
  logic [NDRV*3-1:0]     drv_s0;
  logic [NDRV*3-1:0]     drv_s1;
  logic [1:0]            mode;
  logic                  clr;

  logic                  out_valid, out_valid4;
  logic [2*WIDTH-1:0]    out_val, out_val4;
  logic [3*WIDTH-1:0]    out_str, out_str4;
  logic                  x_sticky, x_sticky4;
  logic [15:0]           x_count;
  logic [3:0]            x_count4;

  strength_resolver #(.WIDTH(WIDTH), .NDRV(NDRV), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .drv_val(drv_val),
    .drv_s0(drv_s0), .drv_s1(drv_s1), .mode(mode),
    .out_valid(out_valid), .out_val(out_val), .out_str(out_str),
    .x_sticky(x_sticky), .x_count(x_count), .clr(clr)
  );

  strength_resolver #(.WIDTH(WIDTH), .NDRV(NDRV), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .drv_val(drv_val),
    .drv_s0(drv_s0), .drv_s1(drv_s1), .mode(mode),
    .out_valid(out_valid4), .out_val(out_val4), .out_str(out_str4),
    .x_sticky(x_sticky4), .x_count(x_count4), .clr(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] v;
    logic [23:0] s;
    int          c;
  } exp_t;

  exp_t q[$];
  int nvec  = 0;
  int nfail = 0;

  logic [7:0] st_val [NDRV];
  logic [2:0] st_s0  [NDRV];
  logic [2:0] st_s1  [NDRV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding vector
  // and arrive exactly two cycles after its sample.
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_val", 32'(out_val), 32'(e.v));
        chk("out_str", 32'(out_str), 32'(e.s));
        chk("latency", 32'(cyc), 32'(e.c));
        $display("vector: val=%h str=%h cycle=%0d", out_val, out_str, cyc);
      end
    end
  end

  task automatic clr_drv();
    for (int d = 0; d < NDRV; d++) begin
      st_val[d] = 8'h00;
      st_s0[d]  = 3'd0;
      st_s1[d]  = 3'd0;
    end
  endtask

  task automatic set_drv(input int d, input logic [7:0] v, input logic [2:0] s0, input logic [2:0] s1);
    st_val[d] = v;
    st_s0[d]  = s0;
    st_s1[d]  = s1;
  endtask

  task automatic drive_inputs(input logic [1:0] m);
    for (int d = 0; d < NDRV; d++) begin
      drv_val[d*WIDTH +: WIDTH] = st_val[d];
      drv_s0[d*3 +: 3]          = st_s0[d];
      drv_s1[d*3 +: 3]          = st_s1[d];
    end
    mode     = m;
    in_valid = 1'b1;
    clr      = 1'b0;
  endtask

  task automatic send(input logic [1:0] m, input logic [15:0] ev, input logic [23:0] es);
    @(posedge clk); #1;
    drive_inputs(m);
    q.push_back('{v: ev, s: es, c: cyc + 2});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      clr      = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      nvec++;
      nfail++;
      $display("FAIL drain: got %0d outstanding results expected 0", q.size());
    end
  endtask

  task automatic vec_strong0();
    clr_drv();
    set_drv(0, 8'h00, 3'd6, 3'd6);
    set_drv(1, 8'hFF, 3'd3, 3'd3);
  endtask

  task automatic vec_x();
    clr_drv();
    set_drv(0, 8'h00, 3'd5, 3'd5);
    set_drv(1, 8'h01, 3'd5, 3'd5);
  endtask

  task automatic vec_z();
    clr_drv();
    set_drv(0, 8'h5A, 3'd0, 3'd0);
    set_drv(1, 8'hA5, 3'd0, 3'd0);
  endtask

  task automatic vec_split();
    clr_drv();
    set_drv(0, 8'h0F, 3'd0, 3'd7);
    set_drv(1, 8'hF0, 3'd2, 3'd0);
  endtask

  task automatic vec_mixed();
    clr_drv();
    set_drv(2, 8'hAA, 3'd7, 3'd7);
    set_drv(3, 8'h00, 3'd6, 3'd6);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    clr      = 1'b0;
    mode     = 2'd0;
    drv_val  = '0;
    drv_s0   = '0;
    drv_s1   = '0;
    clr_drv();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_val",   32'(out_val),   32'h0000AAAA);
    chk("rst_out_str",   32'(out_str),   32'd0);
    chk("rst_x_sticky",  32'(x_sticky),  32'd0);
    chk("rst_x_count",   32'(x_count),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back directed vectors across all modes.
    vec_strong0(); send(2'd0, 16'h0000, {8{3'd6}});
    vec_x();       send(2'd0, 16'h0003, {8{3'd5}});
    vec_x();       send(2'd1, 16'h0000, {8{3'd5}});
    vec_x();       send(2'd2, 16'h0001, {8{3'd5}});
    vec_x();       send(2'd3, 16'h0003, {8{3'd5}});
    vec_z();       send(2'd0, 16'hAAAA, 24'h000000);
    vec_split();   send(2'd0, 16'hAA55, {{4{3'd0}}, {4{3'd7}}});
    vec_mixed();   send(2'd0, 16'h4444, {8{3'd7}});
    idle(1);
    drain();
    chk("batch_x_count",  32'(x_count),   32'd2);
    chk("batch_x_sticky", 32'(x_sticky),  32'd1);
    chk("batch_x_count4", 32'(x_count4),  32'd2);
    idle(2);
    @(negedge clk);
    chk("hold_out_valid", 32'(out_valid), 32'd0);
    chk("hold_out_val",   32'(out_val),   32'h00004444);
    chk("hold_out_str",   32'(out_str),   32'h00FFFFFF);

    @(posedge clk); #1;
    clr = 1'b1;
    idle(1);
    @(negedge clk);
    chk("clr_x_count",  32'(x_count),  32'd0);
    chk("clr_x_sticky", 32'(x_sticky), 32'd0);

    // Twenty consecutive samples alternating X / no-X.
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        vec_x();       send(2'd0, 16'h0003, {8{3'd5}});
      end else begin
        vec_strong0(); send(2'd0, 16'h0000, {8{3'd6}});
      end
    end
    idle(1);
    drain();
    chk("burst_x_count",  32'(x_count),  32'd10);
    chk("burst_x_count4", 32'(x_count4), 32'd10);

    for (int i = 0; i < 10; i++) begin
      vec_x(); send(2'd0, 16'h0003, {8{3'd5}});
    end
    idle(1);
    drain();
    chk("sat_x_count",  32'(x_count),  32'd20);
    chk("sat_x_count4", 32'(x_count4), 32'd15);

    // Clear held across the edge that books a new X result.
    vec_x(); send(2'd0, 16'h0003, {8{3'd5}});
    @(posedge clk); #1;
    in_valid = 1'b0;
    clr      = 1'b1;
    @(posedge clk); #1;
    clr      = 1'b1;
    @(posedge clk); #1;
    clr      = 1'b0;
    drain();
    chk("coinc_x_count",  32'(x_count),  32'd0);
    chk("coinc_x_sticky", 32'(x_sticky), 32'd0);
    chk("coinc_x_count4", 32'(x_count4), 32'd0);

    // Reset while two X samples are in flight: neither may emerge.
    vec_x();
    @(posedge clk); #1;
    drive_inputs(2'd0);
    @(posedge clk); #1;
    drive_inputs(2'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_val",  32'(out_val),  32'h0000AAAA);
    chk("mid_rst_out_str",  32'(out_str),  32'd0);
    chk("mid_rst_x_count",  32'(x_count),  32'd0);
    chk("mid_rst_x_sticky", 32'(x_sticky), 32'd0);
    idle(5);
    chk("post_rst_x_count", 32'(x_count),  32'd0);

    vec_strong0(); send(2'd0, 16'h0000, {8{3'd6}});
    idle(1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
